gcd_lcm_core: RTL and testbench
===============================

GCD_LCM_CORE -- requirements
Module: gcd_lcm_core

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  request pulse, sampled only in IDLE.
REQ-005 SHALL have port Op  input  1  0 = GCD, 1 = LCM; captured with Start.
REQ-006 SHALL have ports A, B  input  WIDTH  operands, captured with Start.
REQ-007 SHALL have port Busy  output  1  high from the cycle after Start is accepted until Done.
REQ-008 SHALL have port Done  output  1  one-cycle pulse when Result is valid.
REQ-009 SHALL have port Result  output  WIDTH  registered result; holds until the next Done.
REQ-010 SHALL have port Overflow  output  1  LCM exceeded WIDTH bits; valid with Done.

Function
REQ-011 SHALL implement FSM states IDLE, GCD, DIV, MUL, FIN.
- IDLE: Start=1 captures Op, A, B and goes to GCD.
- Exception: A==0 or B==0 goes to FIN.
REQ-012 SHALL implement binary GCD in GCD state, one step per cycle:
- both even: shift both right, k++.
- only a even: shift a right. Only b even: shift b right.
- both odd: replace the larger with (larger - smaller).
- a==b: g = a << k.
REQ-013 SHALL, in GCD state at a==b, go to FIN if Op=0, else go to DIV.
REQ-014 SHALL compute q = A_captured / g in DIV with a WIDTH-iteration restoring divide, one bit per cycle; the remainder is discarded (division is exact).
REQ-015 SHALL compute q * B_captured in MUL with a WIDTH-iteration shift-add into a 2*WIDTH accumulator.
- Result = low WIDTH bits.
- Overflow = OR of the high WIDTH bits.
REQ-016 SHALL, in FIN, register Result/Overflow and pulse Done for exactly one cycle, then return to IDLE.
- Busy deasserts in the same cycle Done is high.
REQ-017 SHALL define zero-operand results:
- gcd(0,x) = gcd(x,0) = x; gcd(0,0) = 0.
- LCM with any zero operand = 0, Overflow = 0.
- Done pulses on the second rising edge after Start is sampled.
REQ-018 SHALL ignore Start while Busy=1; captured operands and Op are unaffected.
REQ-019 SHALL, when Start=1 coincides with the Done cycle, ignore it; a new request is accepted only in IDLE on a following cycle.
REQ-020 SHALL bound total latency to at most 4*WIDTH+4 cycles from Start to Done for any operands.
REQ-021 SHALL treat A and B as unsigned.

Reset
REQ-022 SHALL, on reset=1, immediately and asynchronously force:
- state to IDLE.
- Busy=0, Done=0, Result=0, Overflow=0.
- all internal datapath registers to 0.
REQ-023 SHALL abandon any in-flight operation on reset, without a Done pulse.
REQ-024 SHALL accept Start on the first rising edge after reset deasserts.

Configuration
REQ-025 SHALL use macro GCD_LCM_CORE_LCM_EN.
- Defined: DIV/MUL states and the divide/multiply datapath exist; Op selects GCD or LCM.
- Not defined: DIV, MUL and that datapath are absent; Op is ignored; every request returns GCD; Overflow is tied 0.

Structure
REQ-026 SHALL place in shared package gcd_lcm_pkg:
- state enum (IDLE, GCD, DIV, MUL, FIN).
- op enum (OP_GCD=0, OP_LCM=1).
- default width constant 32.
REQ-027 SHALL implement the divide and multiply iterations in one sub-module, seq_divmul, instantiated only under GCD_LCM_CORE_LCM_EN.

Verification
REQ-028 SHALL cover Op=0, A=48, B=18 -> Done once, Result=6, Overflow=0, Busy low after Done.
REQ-029 SHALL cover Op=1, A=21, B=6 -> Result=42, Overflow=0; and Op=1, A=0, B=7 -> Result=0, Done on second edge after Start.
REQ-030 SHALL cover Op=1, A=32'hFFFFFFFF, B=32'hFFFFFFFE -> Result=32'h00000002, Overflow=1, latency at most 132 cycles.
REQ-031 SHALL cover Start pulsed again mid-operation with A=5, B=5 -> ignored; the first request's Result is unchanged; exactly one Done.
REQ-032 SHALL cover reset asserted during the DIV state -> outputs 0 immediately, no Done; next request Op=0, A=12, B=8 -> Result=4.
REQ-033 SHALL cover the build without GCD_LCM_CORE_LCM_EN, Op=1, A=4, B=6 -> Result=2, Overflow=0.

Source files
------------

// File: rtl/gcd_lcm_pkg.sv
// Shared types and constants for the GCD/LCM core.
package gcd_lcm_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GCD  = 3'd1,
        DIV  = 3'd2,
        MUL  = 3'd3,
        FIN  = 3'd4
    } state_t;

    typedef enum logic {
        OP_GCD = 1'b0,
        OP_LCM = 1'b1
    } op_t;

endpackage

// File: rtl/gcd_lcm_core_divmul.sv
// seq_divmul: bit-serial restoring divide (q = dividend / divisor) followed by
// an MSB-first shift-add multiply (q * multiplicand). Each phase takes WIDTH
// cycles; o_last flags the final iteration of whichever phase is running.
module seq_divmul
    import gcd_lcm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic                 i_div,
    input  logic                 i_mul,
    input  logic [WIDTH-1:0]     i_dividend,
    input  logic [WIDTH-1:0]     i_divisor,
    input  logic [WIDTH-1:0]     i_multiplicand,
    output logic                 o_last,
    output logic [2*WIDTH-1:0]   o_product
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;

    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_sub;
    logic               w_fits;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign w_trial  = {r_rem, r_quo[WIDTH-1]};
    assign w_sub    = w_trial - {1'b0, r_divisor};
    assign w_fits   = (w_trial >= {1'b0, r_divisor});
    assign o_last   = (r_cnt == LAST);
    assign o_product = r_acc;

    // Iteration engine; r_quo holds the dividend, then the quotient, and is
    // then consumed MSB-first as the multiplier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
        end else if (i_start) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= i_dividend;
            r_divisor <= i_divisor;
            r_mcand   <= i_multiplicand;
            r_acc     <= '0;
        end else if (i_div || i_mul) begin
            r_cnt <= o_last ? '0 : r_cnt + CW'(1);
            if (i_div) begin
                // A failed trial is below the divisor, so it fits WIDTH bits.
                r_rem <= w_fits ? w_sub[WIDTH-1:0] : w_trial[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], w_fits};
            end else begin
                r_acc <= {r_acc[2*WIDTH-2:0], 1'b0}
                         + (r_quo[WIDTH-1] ? {{WIDTH{1'b0}}, r_mcand} : '0);
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/gcd_lcm_core.sv
// gcd_lcm_core: iterative binary GCD, optionally followed by LCM computed as
// (A / gcd) * B. The LCM path (DIV/MUL states and seq_divmul) exists only
// when GCD_LCM_CORE_LCM_EN is defined; otherwise every request returns GCD.
module gcd_lcm_core
    import gcd_lcm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Overflow
);
    localparam int KW = $clog2(WIDTH) + 1;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_acap;
    logic [WIDTH-1:0] r_bcap;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [KW-1:0]    r_k;

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_diff_ab;
    logic [WIDTH-1:0] w_diff_ba;
    logic             w_zero_cap;

    assign w_g        = r_a << r_k;
    assign w_diff_ab  = r_a - r_b;
    assign w_diff_ba  = r_b - r_a;
    assign w_zero_cap = (r_acap == '0) || (r_bcap == '0);

    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Result   = r_result;
    assign Overflow = r_ovf;

`ifdef GCD_LCM_CORE_LCM_EN
    op_t                r_op;
    logic               w_lcm_sel;
    logic               w_div_start;
    logic               w_last;
    logic [2*WIDTH-1:0] w_product;

    assign w_lcm_sel   = (r_op == OP_LCM);
    assign w_div_start = (r_state == GCD) && (r_a == r_b) && w_lcm_sel;

    seq_divmul #(.WIDTH(WIDTH)) u_divmul (
        .clk            (clk),
        .reset          (reset),
        .i_start        (w_div_start),
        .i_div          (r_state == DIV),
        .i_mul          (r_state == MUL),
        .i_dividend     (r_acap),
        .i_divisor      (w_g),
        .i_multiplicand (r_bcap),
        .o_last         (w_last),
        .o_product      (w_product)
    );
`else
    logic w_unused_op;
    assign w_unused_op = Op;
`endif

    // Control FSM with the binary-GCD datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= '0;
            r_acap   <= '0;
            r_bcap   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_k      <= '0;
`ifdef GCD_LCM_CORE_LCM_EN
            r_op     <= OP_GCD;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Start during the Done cycle is deliberately not taken.
                    if (Start && !r_done) begin
                        r_acap  <= A;
                        r_bcap  <= B;
                        r_a     <= A;
                        r_b     <= B;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
`ifdef GCD_LCM_CORE_LCM_EN
                        r_op    <= op_t'(Op);
`endif
                        r_state <= ((A == '0) || (B == '0)) ? FIN : GCD;
                    end
                end
                GCD: begin
                    if (r_a == r_b) begin
`ifdef GCD_LCM_CORE_LCM_EN
                        r_state <= w_lcm_sel ? DIV : FIN;
`else
                        r_state <= FIN;
`endif
                    end else if (!r_a[0] && !r_b[0]) begin
                        r_a <= r_a >> 1;
                        r_b <= r_b >> 1;
                        r_k <= r_k + KW'(1);
                    end else if (!r_a[0]) begin
                        r_a <= r_a >> 1;
                    end else if (!r_b[0]) begin
                        r_b <= r_b >> 1;
                    end else if (r_a > r_b) begin
                        // Odd minus odd is even and the other operand is odd,
                        // so halving in the same step keeps the gcd and
                        // keeps the iteration count inside the latency bound.
                        r_a <= w_diff_ab >> 1;
                    end else begin
                        r_b <= w_diff_ba >> 1;
                    end
                end
`ifdef GCD_LCM_CORE_LCM_EN
                DIV: begin
                    if (w_last) r_state <= MUL;
                end
                MUL: begin
                    if (w_last) r_state <= FIN;
                end
`endif
                FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                    r_ovf   <= 1'b0;
                    r_result <= w_zero_cap ? (r_acap | r_bcap) : w_g;
`ifdef GCD_LCM_CORE_LCM_EN
                    if (w_lcm_sel) begin
                        r_result <= w_zero_cap ? '0 : w_product[WIDTH-1:0];
                        r_ovf    <= ~w_zero_cap & (|w_product[2*WIDTH-1:WIDTH]);
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_lcm_core.sv
// Self-checking bench for gcd_lcm_core: directed scenarios plus randomized
// requests checked against an arithmetic reference (Euclid, 64-bit LCM).
module tb_gcd_lcm_core;

`ifdef GCD_LCM_CORE_LCM_EN
    localparam bit LCM_EN = 1'b1;
`else
    localparam bit LCM_EN = 1'b0;
`endif
    localparam int W = 32;
    localparam int MAX_LAT = 4 * W + 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         Start;
    logic         Op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;
    logic         Overflow;

    int n_checks = 0;
    int n_pass   = 0;

    gcd_lcm_core #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .Start    (Start),
        .Op       (Op),
        .A        (A),
        .B        (B),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result),
        .Overflow (Overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x_in, input logic [W-1:0] y_in);
        logic [W-1:0] x, y, t;
        x = x_in;
        y = y_in;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic ref_model(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] res, output logic ovf);
        logic [2*W-1:0] l;
        logic [W-1:0]   g;
        g = ref_gcd(a, b);
        if (op && LCM_EN) begin
            if (a == 0 || b == 0) begin
                res = '0;
                ovf = 1'b0;
            end else begin
                l   = (2*W)'(a / g) * (2*W)'(b);
                res = l[W-1:0];
                ovf = |l[2*W-1:W];
            end
        end else begin
            res = g;
            ovf = 1'b0;
        end
    endtask

    // Issue one request from IDLE and observe it; lat counts edges after the capture edge.
    task automatic do_req(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output logic ovf, output int lat,
                          output int extra, output bit busy_ok, output bit timed_out);
        Start = 1'b1; Op = op; A = a; B = b;
        @(posedge clk); #1;
        Start = 1'b0; Op = ~op; A = $urandom; B = $urandom;
        lat = -1; extra = 0; busy_ok = 1'b1; timed_out = 1'b1; res = '0; ovf = 1'b0;
        for (int c = 0; c <= 300; c++) begin
            if (Done === 1'b1) begin
                lat = c; res = Result; ovf = Overflow; timed_out = 1'b0;
                if (Busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (Busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (Done === 1'b1) extra++;
            if (Busy !== 1'b0) busy_ok = 1'b0;
        end
        $display("req op=%0d a=%08h b=%08h -> result=%08h ovf=%0b lat=%0d", op, a, b, res, ovf, lat);
    endtask

    task automatic test_reset();
        logic [W-1:0] res; logic ovf; int lat, extra; bit bok, tmo;
        reset = 1'b1; Start = 1'b0; Op = 1'b0; A = '0; B = '0;
        #1;
        n_checks++; if ({Busy, Done, Overflow} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {Busy, Done, Overflow}); else n_pass++;
        n_checks++; if (Result !== '0) $display("FAIL reset_result: got %h expected 0", Result); else n_pass++;
        #21;
        reset = 1'b0;
        // Start is offered so that the very first edge after release captures it.
        do_req(1'b0, 32'd48, 32'd18, res, ovf, lat, extra, bok, tmo);
        n_checks++; if (tmo) $display("FAIL gcd48_18_timeout: no Done within bound"); else n_pass++;
        n_checks++; if (res !== 32'd6) $display("FAIL gcd48_18_result: got %0d expected 6", res); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL gcd48_18_ovf: got %b expected 0", ovf); else n_pass++;
        n_checks++; if (extra !== 0) $display("FAIL gcd48_18_once: got %0d extra Done expected 0", extra); else n_pass++;
        n_checks++; if (!bok) $display("FAIL gcd48_18_busy: Busy profile wrong got %b expected 1", bok); else n_pass++;
    endtask

    task automatic test_lcm_basic();
        logic [W-1:0] res; logic ovf; int lat, extra; bit bok, tmo;
        do_req(1'b1, 32'd21, 32'd6, res, ovf, lat, extra, bok, tmo);
        n_checks++; if (res !== (LCM_EN ? 32'd42 : 32'd3)) $display("FAIL lcm21_6_result: got %0d expected %0d", res, LCM_EN ? 42 : 3); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL lcm21_6_ovf: got %b expected 0", ovf); else n_pass++;
        do_req(1'b1, 32'd0, 32'd7, res, ovf, lat, extra, bok, tmo);
        n_checks++; if (res !== (LCM_EN ? 32'd0 : 32'd7)) $display("FAIL lcm0_7_result: got %0d expected %0d", res, LCM_EN ? 0 : 7); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL lcm0_7_ovf: got %b expected 0", ovf); else n_pass++;
        n_checks++; if (lat !== 1) $display("FAIL lcm0_7_latency: got %0d expected 1", lat); else n_pass++;
        do_req(1'b1, 32'd4, 32'd6, res, ovf, lat, extra, bok, tmo);
        n_checks++; if (res !== (LCM_EN ? 32'd12 : 32'd2)) $display("FAIL op1_4_6_result: got %0d expected %0d", res, LCM_EN ? 12 : 2); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL op1_4_6_ovf: got %b expected 0", ovf); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [W-1:0] res; logic ovf; int lat, extra; bit bok, tmo;
        do_req(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, res, ovf, lat, extra, bok, tmo);
        n_checks++; if (res !== (LCM_EN ? 32'h2 : 32'h1)) $display("FAIL big_result: got %h expected %h", res, LCM_EN ? 32'h2 : 32'h1); else n_pass++;
        n_checks++; if (ovf !== LCM_EN) $display("FAIL big_ovf: got %b expected %b", ovf, LCM_EN); else n_pass++;
        n_checks++; if (tmo || lat + 1 > MAX_LAT) $display("FAIL big_latency: got %0d expected <= %0d", lat + 1, MAX_LAT); else n_pass++;
    endtask

    task automatic test_zero_ops();
        logic [W-1:0] res; logic ovf; int lat, extra; bit bok, tmo;
        do_req(1'b0, 32'd0, 32'd35, res, ovf, lat, extra, bok, tmo);
        n_checks++; if (res !== 32'd35) $display("FAIL gcd0_x: got %0d expected 35", res); else n_pass++;
        do_req(1'b0, 32'd91, 32'd0, res, ovf, lat, extra, bok, tmo);
        n_checks++; if (res !== 32'd91) $display("FAIL gcdx_0: got %0d expected 91", res); else n_pass++;
        n_checks++; if (lat !== 1) $display("FAIL gcdx_0_latency: got %0d expected 1", lat); else n_pass++;
        do_req(1'b0, 32'd0, 32'd0, res, ovf, lat, extra, bok, tmo);
        n_checks++; if (res !== 32'd0) $display("FAIL gcd0_0: got %0d expected 0", res); else n_pass++;
        n_checks++; if (!bok || extra !== 0) $display("FAIL gcd0_0_handshake: busy_ok=%b extra=%0d expected 1/0", bok, extra); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int ndone = 0;
        logic [W-1:0] res = '0;
        Start = 1'b1; Op = 1'b1; A = 32'd21; B = 32'd6;
        @(posedge clk); #1;
        Start = 1'b0; A = '0; B = '0;
        @(posedge clk); #1;
        Start = 1'b1; Op = 1'b0; A = 32'd5; B = 32'd5;
        @(posedge clk); #1;
        Start = 1'b0;
        for (int c = 0; c < 300 && ndone == 0; c++) begin
            if (Done === 1'b1) begin ndone++; res = Result; end
            else begin @(posedge clk); #1; end
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (Done === 1'b1) ndone++;
        end
        $display("req busy-ignore first=(1,21,6) second=(0,5,5) -> result=%0d dones=%0d", res, ndone);
        n_checks++; if (res !== (LCM_EN ? 32'd42 : 32'd3)) $display("FAIL busy_ignore_result: got %0d expected %0d", res, LCM_EN ? 42 : 3); else n_pass++;
        n_checks++; if (ndone !== 1) $display("FAIL busy_ignore_dones: got %0d expected 1", ndone); else n_pass++;
    endtask

    task automatic test_done_cycle_start();
        bit seen = 1'b0;
        Start = 1'b1; Op = 1'b0; A = 32'd48; B = 32'd18;
        @(posedge clk); #1;
        Start = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            if (Done === 1'b1) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        // Offer a new request exactly in the Done cycle; it must be dropped.
        Start = 1'b1; Op = 1'b0; A = 32'd5; B = 32'd5;
        @(posedge clk); #1;
        Start = 1'b0;
        $display("req done-cycle start (0,5,5) -> busy=%b done=%b result=%0d", Busy, Done, Result);
        n_checks++; if (!seen) $display("FAIL done_cycle_timeout: no Done within bound"); else n_pass++;
        n_checks++; if ({Busy, Done} !== 2'b00) $display("FAIL done_cycle_ignored: got busy/done %b expected 00", {Busy, Done}); else n_pass++;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (Result !== 32'd6) $display("FAIL done_cycle_result: got %0d expected 6", Result); else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        int ndone = 0;
        logic [W-1:0] res; logic ovf; int lat, extra; bit bok, tmo;
        Start = 1'b1; Op = 1'b1; A = 32'hFFFFFFFF; B = 32'hFFFFFFFE;
        @(posedge clk); #1;
        Start = 1'b0;
        // 70 edges lands in DIV when LCM is built in; GCD alone still runs at 20.
        for (int c = 0; c < (LCM_EN ? 70 : 20); c++) begin
            @(posedge clk); #1;
            if (Done === 1'b1) ndone++;
        end
        #2 reset = 1'b1;
        #1;
        $display("req reset mid-op -> busy=%b done=%b result=%h ovf=%b", Busy, Done, Result, Overflow);
        n_checks++; if (ndone !== 0) $display("FAIL midop_early_done: got %0d expected 0", ndone); else n_pass++;
        n_checks++; if ({Busy, Done, Overflow} !== 3'b000) $display("FAIL midop_reset_flags: got %b expected 000", {Busy, Done, Overflow}); else n_pass++;
        n_checks++; if (Result !== '0) $display("FAIL midop_reset_result: got %h expected 0", Result); else n_pass++;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        do_req(1'b0, 32'd12, 32'd8, res, ovf, lat, extra, bok, tmo);
        n_checks++; if (res !== 32'd4) $display("FAIL after_reset_result: got %0d expected 4", res); else n_pass++;
        n_checks++; if (extra !== 0 || tmo) $display("FAIL after_reset_done: extra=%0d timeout=%b expected 0/0", extra, tmo); else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] res, exp_res, a, b, g;
        logic ovf, exp_ovf;
        int lat, extra; bit bok, tmo, op;
        for (int i = 0; i < 24; i++) begin
            op = 1'($urandom_range(0, 1));
            g  = $urandom_range(1, 5000);
            case (i % 4)
                0: begin a = $urandom; b = $urandom; end
                1: begin a = g * $urandom_range(1, 60000); b = g * $urandom_range(1, 60000); end
                2: begin a = g << $urandom_range(0, 10); b = g * $urandom_range(1, 300); end
                default: begin a = (i % 8 == 3) ? 32'd0 : $urandom; b = $urandom_range(0, 100); end
            endcase
            ref_model(op, a, b, exp_res, exp_ovf);
            do_req(op, a, b, res, ovf, lat, extra, bok, tmo);
            n_checks++; if (res !== exp_res) $display("FAIL rand%0d_result: got %h expected %h", i, res, exp_res); else n_pass++;
            n_checks++; if (ovf !== exp_ovf) $display("FAIL rand%0d_ovf: got %b expected %b", i, ovf, exp_ovf); else n_pass++;
            n_checks++; if (tmo || lat + 1 > MAX_LAT) $display("FAIL rand%0d_latency: got %0d expected <= %0d", i, lat + 1, MAX_LAT); else n_pass++;
            n_checks++; if (!bok || extra !== 0) $display("FAIL rand%0d_handshake: busy_ok=%b extra=%0d expected 1/0", i, bok, extra); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_lcm_basic();
        test_overflow();
        test_zero_ops();
        test_busy_ignore();
        test_done_cycle_start();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
